sdu_rx_avg: RTL and testbench
=============================

Name: sdu_rx_avg

Overview:
- Parametrised successor to the single-channel SDUltrasound receive recorder.
- Captures a programmable-length ADC record on each transmit trigger and coherently sums a programmable number of records in on-chip RAM.
- After the final record, streams the scaled sums to the PC interface under a valid/ready handshake.
- Sits between the ADC front end and the host packetiser; drives the SDU sequencing strobes.

Parameters:
- ADC_WIDTH, 16, signed ADC sample width.
- ACC_WIDTH, 32, accumulator/RAM word width; must be >= ADC_WIDTH+1.
- ADDR_WIDTH, 12, log2 of max samples per record (4096).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  strobe: latch cfg_*, arm an averaging run
- abort  in  1  strobe: terminate run, return to IDLE
- trigger  in  1  strobe: transmit fired, begin one record
- cfg_num_samples  in  ADDR_WIDTH+1  samples per record N, 1..2^ADDR_WIDTH
- cfg_num_avgs  in  16  records to sum M, 1..65535
- cfg_shift  in  5  arithmetic right shift applied on playback
- adc_in  in  ADC_WIDTH  signed two's-complement sample, valid every clk
- sdu_rx_en  out  1  high while a record is being captured
- sdu_seq_done_strobe  out  1  1-cycle pulse at end of each non-final record
- sdu_ave_done_strobe  out  1  1-cycle pulse at end of final record
- sdu_rx_data  out  ACC_WIDTH  playback sample
- sdu_rx_valid  out  1  playback data valid
- sdu_rx_ready  in  1  downstream accepts data
- sdu_rx_last  out  1  marks final playback sample
- busy  out  1  high in any state except IDLE
- overflow  out  1  sticky: any accumulation saturated this run

Behaviour:
- Reset values: all outputs 0; state IDLE; address/record counters 0.
- States: IDLE, WAIT_TRIG, RECORD, FLUSH, PLAYBACK.
- IDLE:
  - start latches cfg_* and clears overflow and the record counter r.
  - Next state WAIT_TRIG.
  - cfg_num_samples=0 or cfg_num_avgs=0 is treated as 1.
- WAIT_TRIG: trigger -> RECORD the next cycle. Triggers in any other state are ignored.
- RECORD (sdu_rx_en=1), read-modify-write pipeline:
  - Cycle k issues RAM read of address k.
  - Cycle k+1 writes sum = (r==0 ? 0 : rd_data) + sign_ext(adc_in delayed 1 cycle) to address k.
  - Exactly N samples are captured per record: those present on the N cycles after trigger is sampled.
- FLUSH:
  - One cycle completes the last write.
  - Pulse sdu_seq_done_strobe when r<M-1, then r++ and go to WAIT_TRIG.
  - Otherwise pulse sdu_ave_done_strobe and go to PLAYBACK.
- Arithmetic:
  - Signed add in ACC_WIDTH+1 bits.
  - Saturate to the ACC_WIDTH signed max/min and set overflow.
  - No wrap-around permitted.
- PLAYBACK:
  - Reads addresses 0..N-1 in order.
  - sdu_rx_data = stored sum >>> cfg_shift (arithmetic; shift >= ACC_WIDTH yields sign fill).
  - First valid appears 2 cycles after entering PLAYBACK (RAM read latency 1 plus output register).
  - Data/last are held stable while valid && !ready; the address advances only on valid && ready.
  - Full throughput of 1 word/cycle when ready is held high.
  - sdu_rx_last asserted with address N-1. On the last handshake -> IDLE; busy drops the next cycle.
- abort (any state) -> IDLE next cycle:
  - valid, rx_en and strobes deasserted.
  - RAM contents undefined; the next run rewrites them because r==0 ignores stored data.
  - abort has priority over simultaneous trigger/start/handshake.
- start while busy is ignored.
- Reset mid-operation: identical to abort, plus overflow cleared.
- RAM: inferred simple dual-port, 2^ADDR_WIDTH x ACC_WIDTH, registered read.

Test Plan:
- Basic average: N=4, M=3, adc_in constant 100 each record, shift=0, ready=1 -> two seq_done pulses, one ave_done, playback 300,300,300,300 with last on 4th word.
- Signed ramp plus scaling: N=8, M=4, record sample i = -i, shift=2 -> outputs (-4*i)>>>2 = -i for i=0..7, sign correct.
- Saturation: ACC_WIDTH=17, ADC_WIDTH=16, N=2, M=4, adc_in=32767 -> outputs 65535, overflow=1; the next run with small inputs clears overflow.
- Backpressure: N=5, ready toggled 1,0,0,1,... -> data stable during stalls, exactly 5 handshakes, no duplicates or drops, last only on 5th.
- Boundaries: N=2^ADDR_WIDTH, M=1 -> every address is written once and read back equal to input; N=1 -> single-word playback with last=1.
- Abort/ignored events: abort during RECORD of record 2 -> IDLE next cycle, no strobes; a fresh run yields correct sums free of stale data; trigger during PLAYBACK has no effect.

Source files
------------

// File: rtl/sdu_rx_avg.sv
// Coherent averaging receive recorder: sums M ADC records of N samples in RAM,
// then streams the scaled sums out under a valid/ready handshake.
`timescale 1ns/1ps
module sdu_rx_avg #(
  parameter int ADC_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH:0]   cfg_num_samples,
  input  logic [15:0]           cfg_num_avgs,
  input  logic [4:0]            cfg_shift,
  input  logic [ADC_WIDTH-1:0]  adc_in,
  output logic                  sdu_rx_en,
  output logic                  sdu_seq_done_strobe,
  output logic                  sdu_ave_done_strobe,
  output logic [ACC_WIDTH-1:0]  sdu_rx_data,
  output logic                  sdu_rx_valid,
  input  logic                  sdu_rx_ready,
  output logic                  sdu_rx_last,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TRIG, RECORD, FLUSH, PLAYBACK
  } state_t;

  localparam int CW = ADDR_WIDTH + 1;

  state_t state;

  logic [CW-1:0]  n_cfg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [15:0]    m_cfg;
  logic [15:0]    rec;
  logic [4:0]     shift;

  logic [ACC_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ACC_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic                  rd_ok;
  logic                  load;

  logic signed [ADC_WIDTH-1:0] adc_d;
  logic signed [ACC_WIDTH:0]   base;
  logic signed [ACC_WIDTH:0]   samp;
  logic signed [ACC_WIDTH:0]   sum_w;
  logic [ACC_WIDTH-1:0]        sum_sat;
  logic                        sat;

  assign cnt_inc = cnt + CW'(1);

  // First record ignores RAM so stale data from an aborted run never leaks in
  always_comb begin
    base = '0;
    if (rec != '0)
      base = {rd_data[ACC_WIDTH-1], rd_data};
    samp  = (ACC_WIDTH+1)'(adc_d);
    sum_w = base + samp;
    sat   = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
    sum_sat = sum_w[ACC_WIDTH-1:0];
    if (sat)
      sum_sat = sum_w[ACC_WIDTH]
        ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  assign load = (state == PLAYBACK) && rd_ok
             && (cnt < n_cfg)
             && (!sdu_rx_valid || sdu_rx_ready);

  // Look one word ahead on a load to sustain one word per cycle
  always_comb begin
    rd_addr = cnt[ADDR_WIDTH-1:0];
    if (load)
      rd_addr = cnt_inc[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= sum_sat;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      n_cfg               <= '0;
      m_cfg               <= '0;
      shift               <= '0;
      cnt                 <= '0;
      rec                 <= '0;
      wr_en               <= 1'b0;
      wr_addr             <= '0;
      adc_d               <= '0;
      rd_ok               <= 1'b0;
      sdu_rx_en           <= 1'b0;
      sdu_seq_done_strobe <= 1'b0;
      sdu_ave_done_strobe <= 1'b0;
      sdu_rx_data         <= '0;
      sdu_rx_valid        <= 1'b0;
      sdu_rx_last         <= 1'b0;
      busy                <= 1'b0;
      overflow            <= 1'b0;
    end else begin
      sdu_seq_done_strobe <= 1'b0;
      sdu_ave_done_strobe <= 1'b0;
      wr_en               <= 1'b0;
      if (wr_en && sat)
        overflow <= 1'b1;
      if (abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        sdu_rx_en    <= 1'b0;
        sdu_rx_valid <= 1'b0;
        sdu_rx_last  <= 1'b0;
        cnt          <= '0;
        rd_ok        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              n_cfg <= (cfg_num_samples == '0)
                ? CW'(1) : cfg_num_samples;
              m_cfg <= (cfg_num_avgs == '0)
                ? 16'd1 : cfg_num_avgs;
              shift    <= cfg_shift;
              overflow <= 1'b0;
              rec      <= '0;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (trigger) begin
              cnt       <= '0;
              sdu_rx_en <= 1'b1;
              state     <= RECORD;
            end
          end
          RECORD: begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_WIDTH-1:0];
            adc_d   <= adc_in;
            cnt     <= cnt_inc;
            if (cnt == n_cfg - CW'(1)) begin
              sdu_rx_en <= 1'b0;
              state     <= FLUSH;
            end
          end
          FLUSH: begin
            if (rec < m_cfg - 16'd1) begin
              sdu_seq_done_strobe <= 1'b1;
              rec   <= rec + 16'd1;
              state <= WAIT_TRIG;
            end else begin
              sdu_ave_done_strobe <= 1'b1;
              cnt   <= '0;
              rd_ok <= 1'b0;
              state <= PLAYBACK;
            end
          end
          PLAYBACK: begin
            rd_ok <= 1'b1;
            if (load) begin
              sdu_rx_data  <= $signed(rd_data) >>> shift;
              sdu_rx_last  <= (cnt == n_cfg - CW'(1));
              sdu_rx_valid <= 1'b1;
              cnt          <= cnt_inc;
            end else if (sdu_rx_valid && sdu_rx_ready) begin
              sdu_rx_valid <= 1'b0;
              if (sdu_rx_last) begin
                sdu_rx_last <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdu_rx_avg.sv
// Randomised scoreboard bench for sdu_rx_avg with an array-based averaging model.
`timescale 1ns/1ps
module tb_sdu_rx_avg;

  localparam int AW = 16;
  localparam int CW = 17;
  localparam int DW = 6;
  localparam int SMAX = 65535;
  localparam int SMIN = -65536;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic [DW:0]   cfg_num_samples = '0;
  logic [15:0]   cfg_num_avgs = '0;
  logic [4:0]    cfg_shift = '0;
  logic [AW-1:0] adc_in = '0;
  logic          sdu_rx_en;
  logic          sdu_seq_done_strobe;
  logic          sdu_ave_done_strobe;
  logic [CW-1:0] sdu_rx_data;
  logic          sdu_rx_valid;
  logic          sdu_rx_ready = 1'b1;
  logic          sdu_rx_last;
  logic          busy;
  logic          overflow;

  sdu_rx_avg #(
    .ADC_WIDTH(AW), .ACC_WIDTH(CW), .ADDR_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .trigger(trigger), .cfg_num_samples(cfg_num_samples),
    .cfg_num_avgs(cfg_num_avgs), .cfg_shift(cfg_shift),
    .adc_in(adc_in), .sdu_rx_en(sdu_rx_en),
    .sdu_seq_done_strobe(sdu_seq_done_strobe),
    .sdu_ave_done_strobe(sdu_ave_done_strobe),
    .sdu_rx_data(sdu_rx_data), .sdu_rx_valid(sdu_rx_valid),
    .sdu_rx_ready(sdu_rx_ready), .sdu_rx_last(sdu_rx_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit exp_last_q[$];
  int seq_cnt = 0;
  int ave_cnt = 0;
  int en_cnt = 0;
  int hs_cnt = 0;
  bit stall_prev = 1'b0;
  logic [CW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  int mon_e;
  bit mon_l;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(logic [CW-1:0] v);
    return int'($signed(v));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (sdu_seq_done_strobe) seq_cnt++;
      if (sdu_ave_done_strobe) ave_cnt++;
      if (sdu_rx_en) en_cnt++;
      if (stall_prev) begin
        chk("hold_valid", int'(sdu_rx_valid), 1);
        chk("hold_data", sx(sdu_rx_data), sx(prev_data));
        chk("hold_last", int'(sdu_rx_last), int'(prev_last));
      end
      if (sdu_rx_valid && sdu_rx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0d expected none",
                   sx(sdu_rx_data));
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = exp_last_q.pop_front();
          chk("data", sx(sdu_rx_data), mon_e);
          chk("last", int'(sdu_rx_last), int'(mon_l));
        end
      end
      stall_prev = sdu_rx_valid && !sdu_rx_ready;
      prev_data  = sdu_rx_data;
      prev_last  = sdu_rx_last;
    end
  end

  function automatic int gen(int kind, int i);
    logic [15:0] t;
    t = 16'($urandom);
    case (kind)
      1: return 100;
      2: return -i;
      3: return 32767;
      4: return int'($urandom_range(0, 20)) - 10;
      default: return int'($signed(t));
    endcase
  endfunction

  task automatic do_start(int nc, int mc, int sh);
    cfg_num_samples = 7'(nc);
    cfg_num_avgs    = 16'(mc);
    cfg_shift       = 5'(sh);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seq_cnt = 0; ave_cnt = 0; en_cnt = 0; hs_cnt = 0;
  endtask

  task automatic run(int nc, int mc, int sh, int kind,
                     int rmode, bit tpb);
    int n, m, s, v;
    int acc[64];
    bit ovf, done;
    n = (nc == 0) ? 1 : nc;
    m = (mc == 0) ? 1 : mc;
    ovf = 1'b0;
    do_start(nc, mc, sh);
    for (int r = 0; r < m; r++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      trigger = 1'b1;
      @(posedge clk); #1;
      trigger = 1'b0;
      for (int i = 0; i < n; i++) begin
        s = gen(kind, i);
        adc_in = 16'(s);
        v = ((r == 0) ? 0 : acc[i]) + s;
        if (v > SMAX) begin v = SMAX; ovf = 1'b1; end
        if (v < SMIN) begin v = SMIN; ovf = 1'b1; end
        acc[i] = v;
        @(posedge clk); #1;
      end
      adc_in = 16'($urandom);
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(acc[i] >>> sh);
      exp_last_q.push_back(i == n - 1);
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 40 * n + 50; cyc++) begin
      if (!busy) begin done = 1'b1; break; end
      case (rmode)
        0: sdu_rx_ready = 1'b1;
        1: sdu_rx_ready = (cyc % 3 == 0);
        default: sdu_rx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tpb) trigger = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    trigger = 1'b0;
    sdu_rx_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still %0d expected 0", busy);
    end
    chk("words", hs_cnt, n);
    chk("queue_left", exp_q.size(), 0);
    chk("seq_done", seq_cnt, m - 1);
    chk("ave_done", ave_cnt, 1);
    chk("rx_en_cycles", en_cnt, n * m);
    chk("overflow", int'(overflow), int'(ovf));
    exp_q.delete();
    exp_last_q.delete();
  endtask

  task automatic abort_test();
    do_start(6, 3, 0);
    cfg_num_samples = 7'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat (2) @(posedge clk);
      #1;
      trigger = 1'b1;
      @(posedge clk); #1;
      trigger = 1'b0;
      for (int i = 0; i < ((r == 0) ? 6 : 3); i++) begin
        adc_in = 16'($urandom);
        @(posedge clk); #1;
      end
      if (r == 0) chk("start_ignored", en_cnt, 6);
    end
    abort = 1'b1;
    trigger = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    trigger = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_en", int'(sdu_rx_en), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_seq", seq_cnt, 1);
    chk("abort_ave", ave_cnt, 0);
    chk("abort_words", hs_cnt, 0);
    chk("abort_valid", int'(sdu_rx_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_en", int'(sdu_rx_en), 0);
    chk("rst_seq", int'(sdu_seq_done_strobe), 0);
    chk("rst_ave", int'(sdu_ave_done_strobe), 0);
    chk("rst_data", sx(sdu_rx_data), 0);
    chk("rst_valid", int'(sdu_rx_valid), 0);
    chk("rst_last", int'(sdu_rx_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run(4, 3, 0, 1, 0, 0);
    run(8, 4, 2, 2, 0, 0);
    run(2, 4, 0, 3, 0, 0);
    run(3, 2, 0, 4, 0, 0);
    run(5, 2, 1, 0, 1, 0);
    run(64, 1, 0, 0, 2, 0);
    run(1, 2, 0, 0, 0, 1);
    abort_test();
    run(6, 2, 0, 0, 2, 1);
    run(0, 0, 3, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      run($urandom_range(1, 16), $urandom_range(1, 4),
          $urandom_range(0, 20),
          ($urandom_range(0, 1) == 1) ? 4 : 0,
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
